// File: rtl/sample_loader_pkg.sv
// Shared definitions for the sample loader: default word width, FSM state
// encoding and the full-word RAM byte-enable pattern.
package sample_loader_pkg;

  // Fixed-point data word width used across the neural datapath.
  localparam int N_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_X = 2'd1,
    LOAD_T = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Every RAM write stores a whole word.
  localparam logic [7:0] WE_ALL = 8'hFF;

endpackage

// File: rtl/sample_loader_elem_counter.sv
// Modulo-M element counter with a same-cycle wrap pulse.
// Latency: value updates one cycle after en; wrap is combinational with en.
// Backpressure: none, counts only when en is high.
// Ports: clk, rst (sync, active-high), clr (sync clear), en (count),
//        value (current index 0..M-1), wrap (en on the last index).
module elem_counter
  import sample_loader_pkg::*;
#(
  parameter int M = 5,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         wrap
);

  assign wrap = en && (value == W'(M - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (en) begin
      value <= wrap ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/sample_loader.sv
// Loads a batch of samples from a valid/ready stream into the x and t RAMs.
// Latency: RAM strobe one cycle after each transfer; done one cycle after the last t write.
// Backpressure: s_ready is high exactly while loading; stream words are ignored otherwise.
// Ports: clk/rst (sync active-high); start/batch begin a batch; s_data/s_valid/s_ready
//        input stream; x_addr/x_din/x_we and t_addr/t_din/t_we RAM write ports;
//        busy while loading; done one-cycle pulse; count = samples stored.
module sample_loader
  import sample_loader_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int SX    = 5,
  parameter int SL    = 1,
  parameter int A     = 32,
  parameter int ASTEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  batch,
  input  logic [N-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [A-1:0]  x_addr,
  output logic [N-1:0]  x_din,
  output logic [7:0]    x_we,
  output logic [A-1:0]  t_addr,
  output logic [N*SL-1:0] t_din,
  output logic [7:0]    t_we,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  count
);

  localparam logic [A-1:0] STEP        = A'(ASTEP);
  localparam logic [A-1:0] SAMPLE_STEP = A'(SX * ASTEP);

  state_t state, state_nxt;

  logic [N-1:0]    batch_q;
  logic [N-1:0]    count_inc;
  logic [A-1:0]    x_base;   // address of element 0 of the current sample
  logic [A-1:0]    t_ptr;
  logic [N*SL-1:0] t_asm;
  logic [N*SL-1:0] t_asm_nxt;
  logic [A-1:0]    x_idx, t_idx;
  logic            x_wrap, t_wrap;
  logic            xfer, x_xfer, t_xfer, start_ok;

  assign busy      = (state == LOAD_X) || (state == LOAD_T);
  assign s_ready   = busy;
  assign xfer      = s_valid && s_ready;
  assign x_xfer    = xfer && (state == LOAD_X);
  assign t_xfer    = xfer && (state == LOAD_T);
  assign start_ok  = (state == IDLE) && start;
  assign count_inc = count + N'(1);

  elem_counter #(.M(SX), .W(A)) u_x_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .en    (x_xfer),
    .value (x_idx),
    .wrap  (x_wrap)
  );

  elem_counter #(.M(SL), .W(A)) u_t_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .en    (t_xfer),
    .value (t_idx),
    .wrap  (t_wrap)
  );

  // Target word lands in the lane selected by the target counter; the
  // assembled value including the current word is what gets written.
  always_comb begin
    t_asm_nxt = t_asm;
    for (int k = 0; k < SL; k++) begin
      if (t_idx == A'(k)) begin
        t_asm_nxt[N*k +: N] = s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (batch == '0) ? DONE : LOAD_X;
        end
      end
      LOAD_X: begin
        if (x_wrap) begin
          state_nxt = LOAD_T;
        end
      end
      LOAD_T: begin
        if (t_wrap) begin
          state_nxt = (count_inc == batch_q) ? DONE : LOAD_X;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      batch_q <= '0;
      count   <= '0;
      x_base  <= '0;
      t_ptr   <= '0;
      t_asm   <= '0;
      x_addr  <= '0;
      x_din   <= '0;
      x_we    <= '0;
      t_addr  <= '0;
      t_din   <= '0;
      t_we    <= '0;
      done    <= 1'b0;
    end else begin
      x_we <= '0;
      t_we <= '0;
      // Registered from the DONE state so it trails the last t strobe by one cycle.
      done <= (state == DONE);

      if (start_ok) begin
        batch_q <= batch;
        count   <= '0;
        x_base  <= '0;
        t_ptr   <= '0;
      end

      if (x_xfer) begin
        x_we   <= WE_ALL;
        x_din  <= s_data;
        x_addr <= x_base + x_idx * STEP;
        if (x_wrap) begin
          x_base <= x_base + SAMPLE_STEP;
        end
      end

      if (t_xfer) begin
        t_asm <= t_asm_nxt;
        if (t_wrap) begin
          t_we   <= WE_ALL;
          t_din  <= t_asm_nxt;
          t_addr <= t_ptr;
          t_ptr  <= t_ptr + STEP;
          count  <= count_inc;
        end
      end
    end
  end

endmodule
